id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
- Pipelined LEGv8 instruction-decode stage. Sits between instruction fetch and execution.
- Owns the integer register file and reads two source operands, with write-back bypass and X31 hard-wired to zero.
- Sign-extends the immediate per format and registers everything into a ID/EX pipeline register behind a valid/ready handshake.
- Detects load-use hazards (inserts a one-cycle bubble) and honours a branch flush from EX.

Parameters:
- XLEN, 64, register/data width.
- NREGS, 32, number of architectural registers (power of 2, 2..32). Register NREGS-1 is the zero register.
- CTRL_W, 10, width of the control bundle supplied by the control unit.
- PC_W, 64, program-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction address
- ctrl_in  in  CTRL_W  control bundle from cpu_control for in_instr[31:21]
- reg2loc  in  1  1: second source is Rt [4:0]; 0: second source is Rm [20:16]
- mem_read_in  in  1  instruction is a load
- imm_sel  in  2  00 I [21:10] zero-ext; 01 D [20:12] sign-ext; 10 CB [23:5] sign-ext; 11 B [25:0] sign-ext
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  XLEN  write-back data
- flush  in  1  branch taken in EX: kill the younger instruction
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX accepts it
- out_pc  out  PC_W  registered PC
- out_rs1_data, out_rs2_data  out  XLEN  operands
- out_imm  out  XLEN  extended immediate
- out_rs1, out_rs2, out_rd  out  5  register numbers, for forwarding in EX
- out_ctrl  out  CTRL_W  registered control
- out_mem_read  out  1  registered load flag

Behaviour:
- Field decode:
  - rs1 = instr[9:5].
  - rs2 = reg2loc ? instr[4:0] : instr[20:16].
  - rd = instr[4:0].
  - Register numbers >= NREGS read as zero register.
- Register file:
  - NREGS x XLEN. Reset clears all entries to 0.
  - Write on the clk rising edge when wb_en and wb_addr != NREGS-1. Writes to the zero register are ignored.
  - Reads of the zero register always return 0.
- Bypass: if wb_en and wb_addr equals a source (not the zero register), that operand takes wb_data in the same cycle.
- Immediate: extension per imm_sel to XLEN. For B and CB, the offset is word-scaled (immediate << 2) before extension.
- Hazard is true when all of the following hold:
  - in_valid, out_valid, out_mem_read;
  - out_rd != NREGS-1;
  - out_rd == rs1, or out_rd == rs2.
- Advance is true when !out_valid or out_ready.
- Priority, one case per cycle:
  - rst: out_valid=0; every out_* field 0; register file 0; in_ready=0 while rst is high.
  - flush: out_valid<=0; in_ready=1. Any presented input is consumed and discarded.
  - hazard and advance: out_valid<=0 (bubble); in_ready=0. The instruction is re-decoded next cycle; the hazard clears because the load has left.
  - hazard and !advance: hold everything; in_ready=0.
  - advance: in_ready=1. On the edge, the ID/EX register loads the decoded fields and out_valid<=in_valid.
  - !advance: in_ready=0; the ID/EX register holds.
- Latency: 1 cycle from acceptance to out_valid. Throughput 1 per cycle when there are no hazards and no backpressure.
- While the output is held, out_rs*_data is not refreshed. EX forwarding owns later write-backs.
- Reset mid-stall or mid-flush returns the stage to the reset state immediately (asynchronous).

Test Plan:
- Write-back wb_en=1, wb_addr=3, wb_data=0x1234, then ADD X5,X3,X3 (rs1=rs2=3) accepted next cycle -> out_rs1_data=out_rs2_data=0x1234, out_rd=5, out_valid one cycle after acceptance.
- Same-cycle bypass: wb_addr=7, wb_data=0xAA while decoding rs1=7 -> out_rs1_data=0xAA. wb_addr=31, wb_data=0xFF, then read X31 -> 0.
- LDUR X2 accepted, followed by ADD X4,X2,X1 with out_ready=1 -> in_ready=0 for one cycle, one bubble (out_valid=0), then ADD issues. An independent instruction instead causes no bubble.
- Immediates:
  - CB with instr[23:5]=0x7FFFF -> out_imm=0xFFFF_FFFF_FFFF_FFFC.
  - D with instr[20:12]=0x0FF -> out_imm=0xFF.
  - I with instr[21:10]=0xFFF -> out_imm=0xFFF.
- out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0. flush asserted during the stall -> out_valid=0 next cycle and the input is consumed.
- Assert rst asynchronously while out_valid=1 -> out_valid drops without a clock edge. A later read of X3 returns 0.

Source files
------------

// File: rtl/id_stage_pipelined.sv
// LEGv8 pipelined instruction-decode stage.
// Decodes register fields, reads the integer register file with write-back
// bypass, extends the immediate, and registers the result into the ID/EX
// register behind a valid/ready handshake. Stalls one cycle on a load-use
// dependency and discards the incoming instruction on a branch flush from EX.
module id_stage_pipelined #(
  parameter int XLEN   = 64,
  parameter int NREGS  = 32,
  parameter int CTRL_W = 10,
  parameter int PC_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              reg2loc,
  input  logic              mem_read_in,
  input  logic [1:0]        imm_sel,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [XLEN-1:0]   out_imm,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic [4:0]        out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_mem_read
);

  localparam int         AW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [4:0] ZR = 5'(NREGS - 1);

  // Register numbers beyond the implemented file alias to the zero register.
  function automatic logic [4:0] clamp_reg(input logic [4:0] r);
    return ({27'd0, r} >= 32'(NREGS)) ? ZR : r;
  endfunction

  logic [XLEN-1:0] rf [NREGS];

  logic [4:0]      rs1, rs2, rd, wb_reg;
  logic            wb_write;
  logic [XLEN-1:0] rs1_data, rs2_data, imm;
  logic            hazard, advance;

  // The opcode is decoded by the external control unit; ctrl_in carries it.
  logic unused_opcode;
  assign unused_opcode = ^in_instr[31:26];

  assign rs1      = clamp_reg(in_instr[9:5]);
  assign rs2      = clamp_reg(reg2loc ? in_instr[4:0] : in_instr[20:16]);
  assign rd       = clamp_reg(in_instr[4:0]);
  assign wb_reg   = clamp_reg(wb_addr);
  assign wb_write = wb_en && (wb_reg != ZR);

  // Operand read: zero register first, then same-cycle write-back bypass, then the file.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rs1_data = '0;
    rs2_data = '0;
    if (rs1 != ZR) rs1_data = (wb_write && wb_reg == rs1) ? wb_data : rf[rs1[AW-1:0]];
    if (rs2 != ZR) rs2_data = (wb_write && wb_reg == rs2) ? wb_data : rf[rs2[AW-1:0]];
  end

  // Immediate extension; branch offsets are word offsets, so scale by 4 first.
  always_comb begin
    imm = '0;
    unique case (imm_sel)
      2'b00: imm = {{(XLEN-12){1'b0}}, in_instr[21:10]};
      2'b01: imm = {{(XLEN-9){in_instr[20]}}, in_instr[20:12]};
      2'b10: imm = {{(XLEN-21){in_instr[23]}}, in_instr[23:5], 2'b00};
      2'b11: imm = {{(XLEN-28){in_instr[25]}}, in_instr[25:0], 2'b00};
      default: imm = '0;
    endcase
  end

  // Load-use: the load in ID/EX has not produced data yet, so the consumer waits a cycle.
  assign hazard  = in_valid && out_valid && out_mem_read && (out_rd != ZR) &&
                   ((out_rd == rs1) || (out_rd == rs2));
  assign advance = !out_valid || out_ready;
  assign in_ready = !rst && (flush || (!hazard && advance));

  // Register file write port; the zero register is never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the file is cleared on reset because software may read any register before writing it; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_write) begin
      // NOTE: state is updated with non-blocking assignments so every reader sees the pre-edge value.
      rf[wb_reg[AW-1:0]] <= wb_data;
    end
  end

  // ID/EX pipeline register: flush beats hazard beats normal advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_ctrl     <= '0;
      out_mem_read <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (hazard) begin
      if (advance) out_valid <= 1'b0;
    end else if (advance) begin
      out_valid    <= in_valid;
      out_pc       <= in_pc;
      out_rs1_data <= rs1_data;
      out_rs2_data <= rs2_data;
      out_imm      <= imm;
      out_rs1      <= rs1;
      out_rs2      <= rs2;
      out_rd       <= rd;
      out_ctrl     <= ctrl_in;
      out_mem_read <= mem_read_in;
    end
  end

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Self-checking bench for id_stage_pipelined: directed vectors, expected
// ID/EX contents queued at acceptance and compared by an output monitor.
module tb_id_stage_pipelined;

  localparam int XLEN = 64, NREGS = 32, CTRL_W = 10, PC_W = 64;

  logic              clk, rst;
  logic              in_valid, in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic [CTRL_W-1:0] ctrl_in;
  logic              reg2loc, mem_read_in;
  logic [1:0]        imm_sel;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              flush;
  logic              out_valid, out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [XLEN-1:0]   out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]        out_rs1, out_rs2, out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_mem_read;

  id_stage_pipelined #(.XLEN(XLEN), .NREGS(NREGS), .CTRL_W(CTRL_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .ctrl_in(ctrl_in), .reg2loc(reg2loc), .mem_read_in(mem_read_in), .imm_sel(imm_sel),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ctrl(out_ctrl), .out_mem_read(out_mem_read)
  );

  typedef struct {
    logic [63:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  ctrl;
    logic        mem_read;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   waits;
  logic ov;
  exp_t dropped;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, d1, d2, imm,
                              input logic [4:0] r1, r2, rd,
                              input logic [9:0] c, input logic mr);
    exp_t e;
    e.pc = pc; e.rs1_data = d1; e.rs2_data = d2; e.imm = imm;
    e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.ctrl = c; e.mem_read = mr;
    return e;
  endfunction

  // Present one instruction and wait until it is accepted; queue its expected ID/EX image.
  task automatic issue(input logic [31:0] instr, input logic r2l, input logic [1:0] isel,
                       input exp_t e, output int nwait, output logic ov_acc);
    in_valid = 1'b1; in_instr = instr; in_pc = e.pc; ctrl_in = e.ctrl;
    mem_read_in = e.mem_read; reg2loc = r2l; imm_sel = isel;
    nwait = 0; ov_acc = 1'b0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ov_acc = out_valid;
        @(posedge clk); #1;
        return;
      end
      nwait++;
      if (nwait > 20) begin
        check("issue_timeout", 64'(nwait), 64'd0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  // Output monitor: every transfer to EX must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("mon_unexpected_output", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("mon_pc",       out_pc,       e.pc);
        check("mon_rs1_data", out_rs1_data, e.rs1_data);
        check("mon_rs2_data", out_rs2_data, e.rs2_data);
        check("mon_imm",      out_imm,      e.imm);
        check("mon_rs1",      64'(out_rs1), 64'(e.rs1));
        check("mon_rs2",      64'(out_rs2), 64'(e.rs2));
        check("mon_rd",       64'(out_rd),  64'(e.rd));
        check("mon_ctrl",     64'(out_ctrl), 64'(e.ctrl));
        check("mon_mem_read", 64'(out_mem_read), 64'(e.mem_read));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; ctrl_in = '0;
    reg2loc = 1'b0; mem_read_in = 1'b0; imm_sel = 2'b00;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_pc",    out_pc,         64'd0);
    check("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    check("rst_out_rs1_data", out_rs1_data, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Write-back then read: ADD X5,X3,X3
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h1234;
    @(posedge clk); #1;
    wb_en = 1'b0;
    issue({11'h458, 5'd3, 6'd0, 5'd3, 5'd5}, 1'b0, 2'b00,
          mk(64'h100, 64'h1234, 64'h1234, 64'hC0, 5'd3, 5'd3, 5'd5, 10'h2A5, 1'b0), waits, ov);
    in_valid = 1'b0;
    check("wb_read_waits", 64'(waits), 64'd0);
    check("latency_out_valid", 64'(out_valid), 64'd1);

    // Same-cycle bypass on X7
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'hAA;
    issue({11'h458, 5'd0, 6'd0, 5'd7, 5'd8}, 1'b0, 2'b00,
          mk(64'h110, 64'hAA, 64'h0, 64'h0, 5'd7, 5'd0, 5'd8, 10'h155, 1'b0), waits, ov);
    // Writing X31 is ignored and must not bypass
    wb_addr = 5'd31; wb_data = 64'hFF;
    issue({11'h458, 5'd31, 6'd0, 5'd31, 5'd9}, 1'b0, 2'b00,
          mk(64'h114, 64'h0, 64'h0, 64'h7C0, 5'd31, 5'd31, 5'd9, 10'h0F0, 1'b0), waits, ov);
    wb_en = 1'b0;
    issue({11'h458, 5'd31, 6'd0, 5'd31, 5'd9}, 1'b0, 2'b00,
          mk(64'h118, 64'h0, 64'h0, 64'h7C0, 5'd31, 5'd31, 5'd9, 10'h0F0, 1'b0), waits, ov);

    // Immediates, back to back
    issue({8'h54, 19'h7FFFF, 5'd0}, 1'b1, 2'b10,
          mk(64'h120, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 5'd31, 5'd0, 5'd0, 10'h301, 1'b0), waits, ov);
    issue({11'h7C0, 9'h0FF, 2'b00, 5'd3, 5'd7}, 1'b1, 2'b01,
          mk(64'h124, 64'h1234, 64'hAA, 64'hFF, 5'd3, 5'd7, 5'd7, 10'h0C3, 1'b0), waits, ov);
    issue({11'h7C0, 9'h100, 2'b00, 5'd7, 5'd3}, 1'b1, 2'b01,
          mk(64'h128, 64'hAA, 64'h1234, 64'hFFFF_FFFF_FFFF_FF00, 5'd7, 5'd3, 5'd3, 10'h0C3, 1'b0), waits, ov);
    issue({10'h244, 12'hFFF, 5'd7, 5'd1}, 1'b0, 2'b00,
          mk(64'h12C, 64'hAA, 64'h0, 64'hFFF, 5'd7, 5'd31, 5'd1, 10'h011, 1'b0), waits, ov);
    issue({6'b000101, 26'h2000000}, 1'b0, 2'b11,
          mk(64'h130, 64'h0, 64'h0, 64'hFFFF_FFFF_F800_0000, 5'd0, 5'd0, 5'd0, 10'h200, 1'b0), waits, ov);
    check("b2b_no_stall", 64'(waits), 64'd0);

    // Load-use: LDUR X2,[X3,#8] then ADD X4,X2,X1
    issue({11'h7C2, 9'd8, 2'b00, 5'd3, 5'd2}, 1'b0, 2'b01,
          mk(64'h200, 64'h1234, 64'h0, 64'h8, 5'd3, 5'd0, 5'd2, 10'h3C1, 1'b1), waits, ov);
    issue({11'h458, 5'd1, 6'd0, 5'd2, 5'd4}, 1'b0, 2'b00,
          mk(64'h204, 64'h0, 64'h0, 64'h40, 5'd2, 5'd1, 5'd4, 10'h2A5, 1'b0), waits, ov);
    check("loaduse_stall_cycles", 64'(waits), 64'd1);
    check("loaduse_bubble",       64'(ov),    64'd0);
    // Independent instruction after a load: no bubble
    issue({11'h7C2, 9'd8, 2'b00, 5'd3, 5'd2}, 1'b0, 2'b01,
          mk(64'h208, 64'h1234, 64'h0, 64'h8, 5'd3, 5'd0, 5'd2, 10'h3C1, 1'b1), waits, ov);
    issue({11'h458, 5'd1, 6'd0, 5'd3, 5'd4}, 1'b0, 2'b00,
          mk(64'h20C, 64'h1234, 64'h0, 64'h40, 5'd3, 5'd1, 5'd4, 10'h2A5, 1'b0), waits, ov);
    check("indep_stall_cycles", 64'(waits), 64'd0);
    check("indep_no_bubble",    64'(ov),    64'd1);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure for 3 cycles with a pending input, then flush
    out_ready = 1'b0;
    issue({11'h458, 5'd7, 6'd0, 5'd3, 5'd6}, 1'b0, 2'b00,
          mk(64'h300, 64'h1234, 64'hAA, 64'h1C0, 5'd3, 5'd7, 5'd6, 10'h1E1, 1'b0), waits, ov);
    in_instr = {11'h458, 5'd3, 6'd0, 5'd3, 5'd10};
    in_pc = 64'h304;
    for (int i = 0; i < 3; i++) begin
      wb_en = (i == 1); wb_addr = 5'd3; wb_data = 64'h5555;
      @(negedge clk);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_pc",    out_pc,         64'h300);
      check("stall_rs1_data",  out_rs1_data,   64'h1234);
      check("stall_out_rd",    64'(out_rd),    64'd6);
      @(posedge clk); #1;
    end
    wb_en = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    dropped = exp_q.pop_back();
    check("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("flush_input_consumed", 64'(out_valid), 64'd0);

    // Asynchronous reset while holding a valid output
    out_ready = 1'b0;
    issue({11'h458, 5'd3, 6'd0, 5'd3, 5'd5}, 1'b0, 2'b00,
          mk(64'h400, 64'h5555, 64'h5555, 64'hC0, 5'd3, 5'd3, 5'd5, 10'h2A5, 1'b0), waits, ov);
    in_valid = 1'b0;
    check("pre_arst_out_valid", 64'(out_valid), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd0);
    check("arst_out_pc",    out_pc,         64'd0);
    dropped = exp_q.pop_back();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    issue({11'h458, 5'd31, 6'd0, 5'd3, 5'd11}, 1'b0, 2'b00,
          mk(64'h500, 64'h0, 64'h0, 64'h7C0, 5'd3, 5'd31, 5'd11, 10'h155, 1'b0), waits, ov);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
